cache_fill_ctrl: RTL

Miss-handling and line-refill controller for the 4-way set-associative cache. It consumes the victim way from the 4-element LRU tracker and writes back the victim line if it is dirty. It then refills the line word-by-word from memory into that way and drives the tracker's update port, so the refilled way becomes most-recently-used. It sits between the cache tag/data arrays, the LRU tracker and the memory request port.

---
 rtl/cache_fill_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss handling and line refill for a 4-way cache.
// Optional victim writeback is compiled in with CACHE_WRITEBACK_EN.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   miss_*            miss request in, miss_ready_o when idle
//   victim_*          LRU victim way/dirty/base, sampled on accept
//   way_rd_*          combinational victim word read (writeback)
//   way_wr_*          one-word data array write (refill)
//   mem_req_*         memory request, valid/ready
//   mem_resp_*        memory read data
//   lru_index_o/lru_update_o  LRU tracker update port
//   done_o            one-cycle refill-complete pulse
module cache_fill_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              miss_v_i,
  input  logic [ADDR_W-1:0]                 miss_addr_i,
  output logic                              miss_ready_o,
  input  logic [1:0]                        victim_way_i,
  input  logic                              victim_dirty_i,
  input  logic [ADDR_W-1:0]                 victim_addr_i,
  output logic [$clog2(WORDS_PER_LINE)-1:0] way_rd_word_o,
  input  logic [DATA_W-1:0]                 way_rd_data_i,
  output logic                              way_wr_v_o,
  output logic [1:0]                        way_wr_way_o,
  output logic [$clog2(WORDS_PER_LINE)-1:0] way_wr_word_o,
  output logic [DATA_W-1:0]                 way_wr_data_o,
  output logic                              mem_req_v_o,
  output logic                              mem_req_we_o,
  output logic [ADDR_W-1:0]                 mem_req_addr_o,
  output logic [DATA_W-1:0]                 mem_req_data_o,
  input  logic                              mem_req_ready_i,
  input  logic                              mem_resp_v_i,
  input  logic [DATA_W-1:0]                 mem_resp_data_i,
  output logic [1:0]                        lru_index_o,
  output logic                              lru_update_o,
  output logic                              done_o
);

  localparam int WL = $clog2(WORDS_PER_LINE);
  localparam int TW = ADDR_W - WL;
  localparam logic [WL-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef CACHE_WRITEBACK_EN
    S_WB_REQ,
`endif
    S_FILL_REQ,
    S_FILL_WAIT,
    S_UPDATE
  } state_t;

  state_t        state_q, state_d;
  logic [WL-1:0] cnt_q, cnt_d;
  logic [TW-1:0] mbase_q, mbase_d;
  logic [1:0]    way_q, way_d;
  logic          last_w;

`ifdef CACHE_WRITEBACK_EN
  logic [TW-1:0] vbase_q, vbase_d;
  logic          unused_w;
  assign unused_w = ^{miss_addr_i[WL-1:0],
                      victim_addr_i[WL-1:0]};
`else
  logic          unused_w;
  assign unused_w = ^{miss_addr_i[WL-1:0],
                      victim_addr_i,
                      victim_dirty_i,
                      way_rd_data_i};
`endif

  assign last_w = &cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mbase_q <= '0;
      way_q   <= '0;
`ifdef CACHE_WRITEBACK_EN
      vbase_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mbase_q <= mbase_d;
      way_q   <= way_d;
`ifdef CACHE_WRITEBACK_EN
      vbase_q <= vbase_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mbase_d        = mbase_q;
    way_d          = way_q;
`ifdef CACHE_WRITEBACK_EN
    vbase_d        = vbase_q;
`endif
    miss_ready_o   = 1'b0;
    way_rd_word_o  = '0;
    way_wr_v_o     = 1'b0;
    way_wr_way_o   = '0;
    way_wr_word_o  = '0;
    way_wr_data_o  = '0;
    mem_req_v_o    = 1'b0;
    mem_req_we_o   = 1'b0;
    mem_req_addr_o = '0;
    mem_req_data_o = '0;
    lru_index_o    = '0;
    lru_update_o   = 1'b0;
    done_o         = 1'b0;
    // Outputs stay quiet during reset so an abort never
    // leaks a write, request or update pulse.
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          miss_ready_o = 1'b1;
          if (miss_v_i) begin
            mbase_d = miss_addr_i[ADDR_W-1:WL];
            way_d   = victim_way_i;
            cnt_d   = '0;
`ifdef CACHE_WRITEBACK_EN
            vbase_d = victim_addr_i[ADDR_W-1:WL];
            state_d = victim_dirty_i ? S_WB_REQ
                                     : S_FILL_REQ;
`else
            state_d = S_FILL_REQ;
`endif
          end
        end
`ifdef CACHE_WRITEBACK_EN
        S_WB_REQ: begin
          way_rd_word_o  = cnt_q;
          mem_req_v_o    = 1'b1;
          mem_req_we_o   = 1'b1;
          mem_req_addr_o = {vbase_q, cnt_q};
          mem_req_data_o = way_rd_data_i;
          if (mem_req_ready_i) begin
            // Counter wraps to 0 after the last word,
            // ready for the fill phase.
            cnt_d = cnt_q + ONE;
            if (last_w) state_d = S_FILL_REQ;
          end
        end
`endif
        S_FILL_REQ: begin
          mem_req_v_o    = 1'b1;
          mem_req_addr_o = {mbase_q, cnt_q};
          if (mem_req_ready_i) state_d = S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (mem_resp_v_i) begin
            way_wr_v_o    = 1'b1;
            way_wr_way_o  = way_q;
            way_wr_word_o = cnt_q;
            way_wr_data_o = mem_resp_data_i;
            cnt_d         = cnt_q + ONE;
            state_d       = last_w ? S_UPDATE
                                   : S_FILL_REQ;
          end
        end
        S_UPDATE: begin
          lru_update_o = 1'b1;
          lru_index_o  = way_q;
          done_o       = 1'b1;
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
